// File: rtl/chan_cfg_pkg.sv
// Shared constants for the channel-table configuration sequencer:
// opcodes, command/status bit positions and the sequencer state encoding.
package chan_cfg_pkg;

  // Command opcodes carried in cmd_in[30:28]
  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_WRITE = 3'd1;
  localparam logic [2:0] OP_FILL  = 3'd2;
  localparam logic [2:0] OP_CLEAR = 3'd3;
  localparam logic [2:0] OP_READ  = 3'd4;

  // Command word field positions
  localparam int unsigned CMD_TGL_BIT    = 31;
  localparam int unsigned CMD_OP_LSB     = 28;
  localparam int unsigned CMD_OP_W       = 3;
  localparam int unsigned FIELD_ADDR_LSB = 16;

  // Status word bit positions (address and data fields share the command layout)
  localparam int unsigned STAT_BUSY_BIT = 31;
  localparam int unsigned STAT_ACK_BIT  = 30;
  localparam int unsigned STAT_ERR_BIT  = 29;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DECODE  = 3'd1,
    ST_WRITE   = 3'd2,
    ST_FILL    = 3'd3,
    ST_RD_ADDR = 3'd4,
    ST_RD_WAIT = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

  // Opcodes above READ are reserved and flagged as errors
  function automatic logic op_is_legal(input logic [2:0] op);
    return (op <= OP_READ);
  endfunction

endpackage

// File: rtl/chan_cfg_addr_ctr.sv
// Fill address counter: synchronous clear, count enable, terminal count at all-ones.
module chan_cfg_addr_ctr #(
  parameter int unsigned W = 9
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;

  // Count up on enable; never wraps because the owner stops enabling at terminal count
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !tc_o) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == '1);

endmodule

// File: rtl/chan_cfg_sequencer.sv
// Channel-table configuration sequencer: executes toggle-handshaked software
// commands (write, fill, clear, read) against a shared table port that is
// only usable in cycles where the datapath grants access.
module chan_cfg_sequencer
  import chan_cfg_pkg::*;
#(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 16
) (
  input  logic              OPB_Clk,
  input  logic              OPB_Rst,
  input  logic [31:0]       cmd_in,
  input  logic              tbl_grant,
  output logic [ADDR_W-1:0] tbl_addr,
  output logic [DATA_W-1:0] tbl_din,
  output logic              tbl_we,
  input  logic [DATA_W-1:0] tbl_dout,
  output logic [31:0]       status_out
);

  logic [31:0]       cmd_q;
  state_e            state_q;
  logic              tgl_q;
  logic              ack_q;
  logic              err_q;
  logic              busy_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] last_q;
  logic [DATA_W-1:0] din_q;
  logic [DATA_W-1:0] rb_q;

  logic [ADDR_W-1:0] ctr;
  logic              ctr_tc;
  logic              ctr_clr;
  logic              ctr_en;

  logic [2:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              pending;
  logic              unused_cmd;

  assign cmd_op     = cmd_q[CMD_OP_LSB +: CMD_OP_W];
  assign cmd_addr   = cmd_q[FIELD_ADDR_LSB +: ADDR_W];
  assign cmd_data   = cmd_q[DATA_W-1:0];
  assign pending    = cmd_q[CMD_TGL_BIT] ^ ack_q;
  assign unused_cmd = ^cmd_q;

  // Fill counter restarts from zero on every decode
  assign ctr_clr = (state_q == ST_DECODE);
  assign ctr_en  = (state_q == ST_FILL) && tbl_grant;

  chan_cfg_addr_ctr #(
    .W (ADDR_W)
  ) u_addr_ctr (
    .clk_i (OPB_Clk),
    .rst_i (OPB_Rst),
    .clr_i (ctr_clr),
    .en_i  (ctr_en),
    .cnt_o (ctr),
    .tc_o  (ctr_tc)
  );

  // Command sampling and sequencer state machine
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      cmd_q   <= '0;
      state_q <= ST_IDLE;
      tgl_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      last_q  <= '0;
      din_q   <= '0;
      rb_q    <= '0;
    end else begin
      cmd_q <= cmd_in;
      case (state_q)
        ST_IDLE: begin
          if (pending) begin
            busy_q  <= 1'b1;
            state_q <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          tgl_q <= cmd_q[CMD_TGL_BIT];
          err_q <= !op_is_legal(cmd_op);
          case (cmd_op)
            OP_WRITE: begin
              addr_q  <= cmd_addr;
              din_q   <= cmd_data;
              state_q <= ST_WRITE;
            end
            OP_FILL: begin
              din_q   <= cmd_data;
              state_q <= ST_FILL;
            end
            OP_CLEAR: begin
              din_q   <= '0;
              state_q <= ST_FILL;
            end
            OP_READ: begin
              addr_q  <= cmd_addr;
              state_q <= ST_RD_ADDR;
            end
            default: state_q <= ST_DONE;
          endcase
        end
        ST_WRITE: begin
          if (tbl_grant) begin
            state_q <= ST_DONE;
          end
        end
        ST_FILL: begin
          // Track the written address so it holds once the fill completes
          if (tbl_grant) begin
            addr_q <= ctr;
            if (ctr_tc) begin
              state_q <= ST_DONE;
            end
          end
        end
        ST_RD_ADDR: begin
          if (tbl_grant) begin
            state_q <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          rb_q    <= tbl_dout;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          ack_q   <= tgl_q;
          last_q  <= addr_q;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Write strobe follows the grant in the same cycle so each granted cycle lands one write
  assign tbl_we   = tbl_grant && ((state_q == ST_WRITE) || (state_q == ST_FILL));
  assign tbl_addr = (state_q == ST_FILL) ? ctr : addr_q;
  assign tbl_din  = din_q;

  // Status word assembly
  always_comb begin
    status_out                                 = '0;
    status_out[STAT_BUSY_BIT]                  = busy_q;
    status_out[STAT_ACK_BIT]                   = ack_q;
    status_out[STAT_ERR_BIT]                   = err_q;
    status_out[FIELD_ADDR_LSB +: ADDR_W]       = last_q;
    status_out[DATA_W-1:0]                     = rb_q;
  end

endmodule

// File: tb/tb_chan_cfg_sequencer.sv
// Scoreboard bench for chan_cfg_sequencer: commands push expected table
// writes and status words; a negedge monitor pops and compares them.
module tb_chan_cfg_sequencer;

  localparam int unsigned AW   = 9;
  localparam int unsigned DW   = 16;
  localparam int unsigned NENT = 512;

  logic          clk;
  logic          rst;
  logic [31:0]   cmd_in;
  logic          grant;
  logic [AW-1:0] tbl_addr;
  logic [DW-1:0] tbl_din;
  logic          tbl_we;
  logic [DW-1:0] tbl_dout;
  logic [31:0]   status_out;

  chan_cfg_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .OPB_Clk    (clk),
    .OPB_Rst    (rst),
    .cmd_in     (cmd_in),
    .tbl_grant  (grant),
    .tbl_addr   (tbl_addr),
    .tbl_din    (tbl_din),
    .tbl_we     (tbl_we),
    .tbl_dout   (tbl_dout),
    .status_out (status_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [DW-1:0] mmem [NENT];
  logic          m_ack, m_err, tgl;
  logic [AW-1:0] m_last;
  logic [DW-1:0] m_rb;
  logic [24:0]   exp_wr_q [$];
  logic [31:0]   exp_st_q [$];

  logic mon_en   = 1'b0;
  logic ack_seen = 1'b0;
  int   gmode    = 0;

  // table BFM: one-cycle read latency, loaded from the model image on the first edge
  logic [DW-1:0] tbl_mem [NENT];
  logic          bfm_loaded = 1'b0;
  always @(posedge clk) begin
    if (!bfm_loaded) begin
      for (int i = 0; i < NENT; i++) tbl_mem[i] <= mmem[i];
      bfm_loaded <= 1'b1;
    end else if (tbl_we) begin
      tbl_mem[tbl_addr] <= tbl_din;
    end
    tbl_dout <= tbl_mem[tbl_addr];
  end

  // grant driver: 0 = always, 1 = alternate, 2 = random
  always @(posedge clk) begin
    #1;
    case (gmode)
      0:       grant = 1'b1;
      1:       grant = ~grant;
      default: grant = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=0x%08h exp=0x%08h", name, act, exp);
    end
  endtask

  // monitor: table writes and status acknowledgements against the scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      if (tbl_we) begin
        if (exp_wr_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write addr=0x%03h data=0x%04h", tbl_addr, tbl_din);
        end else begin
          chk("write_addr_data", 32'({tbl_addr, tbl_din}), 32'(exp_wr_q.pop_front()));
          chk("busy_during_write", 32'(status_out[31]), 32'(1));
        end
      end
      if (status_out[30] != ack_seen) begin
        ack_seen = status_out[30];
        if (exp_st_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ack status=0x%08h", status_out);
        end else begin
          chk("status_word", status_out, exp_st_q.pop_front());
        end
      end
    end
  end

  // behavioural effect of one command on the table and status
  task automatic model_apply(input logic [2:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [DW-1:0] fv;
    case (op)
      3'd1: begin
        exp_wr_q.push_back({a, d});
        mmem[a] = d;
        m_last  = a;
      end
      3'd2, 3'd3: begin
        fv = (op == 3'd2) ? d : DW'(0);
        for (int i = 0; i < NENT; i++) begin
          exp_wr_q.push_back({AW'(i), fv});
          mmem[i] = fv;
        end
        m_last = AW'(NENT - 1);
      end
      3'd4: begin
        m_rb   = mmem[a];
        m_last = a;
      end
      default: ;
    endcase
    m_err = (op > 3'd4);
    m_ack = tgl;
    exp_st_q.push_back({1'b0, m_ack, m_err, 4'b0, m_last, m_rb});
  endtask

  task automatic issue(input logic [2:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [31:0] c;
    tgl = ~tgl;
    model_apply(op, a, d);
    c          = 32'(0);
    c[31]      = tgl;
    c[30:28]   = op;
    c[27:25]   = 3'($urandom);
    c[24:16]   = a;
    c[15:0]    = d;
    cmd_in     = c;
  endtask

  task automatic wait_ack(input int limit);
    logic done;
    done = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (status_out[30] == tgl && !status_out[31]) begin
        done = 1'b1;
        break;
      end
    end
    #1;
    chk("ack_within_budget", 32'(done), 32'(1));
    chk("writes_outstanding", 32'(exp_wr_q.size()), 32'(0));
    chk("status_outstanding", 32'(exp_st_q.size()), 32'(0));
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    issue(op, a, d);
    wait_ack(4000);
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  initial begin
    int we_k, ack_k, fills;
    logic [2:0] op;
    rst    = 1'b1;
    cmd_in = 32'(0);
    grant  = 1'b1;
    tgl    = 1'b0;
    m_ack  = 1'b0;
    m_err  = 1'b0;
    m_last = '0;
    m_rb   = '0;
    for (int i = 0; i < NENT; i++) mmem[i] = DW'($urandom);
    mmem[3] = 16'hCAFE;

    // reset state
    repeat (3) @(negedge clk);
    chk("reset_status", status_out, 32'(0));
    chk("reset_we", 32'(tbl_we), 32'(0));
    chk("reset_addr", 32'(tbl_addr), 32'(0));
    chk("reset_din", 32'(tbl_din), 32'(0));
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // single write with grant held: write 3 cycles and ack 5 cycles after the toggle
    gmode = 0;
    @(negedge clk);
    issue(3'd1, 9'h05A, 16'hBEEF);
    we_k  = 0;
    ack_k = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (tbl_we && we_k == 0) we_k = k;
      if (status_out[30] == tgl) begin
        ack_k = k;
        break;
      end
    end
    #1;
    chk("write_latency", 32'(we_k), 32'(3));
    chk("ack_latency", 32'(ack_k), 32'(5));
    chk("writes_outstanding", 32'(exp_wr_q.size()), 32'(0));
    repeat (3) @(negedge clk);

    // readback of a preloaded entry
    gmode = 2;
    run_cmd(3'd4, 9'h003, 16'h0000);
    chk("read_cafe", 32'(status_out[15:0]), 32'h0000CAFE);

    // illegal opcode sets error, NOP clears it
    run_cmd(3'd6, 9'h011, 16'h5555);
    chk("err_set", 32'(status_out[29]), 32'(1));
    run_cmd(3'd0, 9'h000, 16'h0000);
    chk("err_cleared", 32'(status_out[29]), 32'(0));

    // fill with alternating grant
    gmode = 1;
    run_cmd(3'd2, 9'h000, 16'h1234);
    chk("fill_last_addr", 32'(status_out[24:16]), 32'h1FF);

    // double toggle while busy produces no extra command
    gmode = 2;
    issue(3'd3, 9'h000, 16'h0000);
    repeat (20) @(negedge clk);
    cmd_in[31] = ~cmd_in[31];
    repeat (7) @(negedge clk);
    cmd_in[31] = ~cmd_in[31];
    wait_ack(4000);
    repeat (40) @(negedge clk);
    chk("idle_after_double_toggle", 32'(status_out[31]), 32'(0));
    chk("no_extra_writes", 32'(exp_wr_q.size()), 32'(0));

    // randomized command stream
    fills = 0;
    for (int n = 0; n < 30; n++) begin
      op = 3'($urandom_range(0, 7));
      if (op == 3'd2 || op == 3'd3) begin
        if (fills >= 3) op = 3'd1;
        else fills++;
      end
      run_cmd(op, AW'($urandom), DW'($urandom));
    end

    // reset mid-fill aborts, then the still-set toggle restarts the fill
    gmode = 0;
    if (tgl) run_cmd(3'd0, 9'h000, 16'h0000);
    issue(3'd2, 9'h000, 16'hA5C3);
    we_k = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      #1;
      if (tbl_we && tbl_addr == 9'd100) begin
        we_k = 1;
        break;
      end
    end
    chk("reached_fill_addr_100", 32'(we_k), 32'(1));
    rst    = 1'b1;
    mon_en = 1'b0;
    @(negedge clk);
    #1;
    chk("abort_we", 32'(tbl_we), 32'(0));
    chk("abort_status", status_out, 32'(0));
    exp_wr_q.delete();
    exp_st_q.delete();
    m_err    = 1'b0;
    m_last   = '0;
    m_rb     = '0;
    model_apply(3'd2, 9'h000, 16'hA5C3);
    ack_seen = 1'b0;
    rst      = 1'b0;
    mon_en   = 1'b1;
    wait_ack(4000);
    chk("restart_last_addr", 32'(status_out[24:16]), 32'h1FF);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
